// File: rtl/vsq_quantizer_if.sv
// Handshake bundle for the VSQ quantizer: wide element input stream and
// narrow quantized element + scale exponent output stream.
interface vsq_quantizer_if #(
  parameter int IN_W = 24,
  parameter int Q_W  = 4,
  parameter int SF_W = 8
);
  logic                   vsq_en;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [Q_W-1:0]  out_q;
  logic [SF_W-1:0]        out_sf;
  logic                   out_last;

  modport master (
    output vsq_en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_q, out_sf, out_last
  );

  modport slave (
    input  vsq_en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_q, out_sf, out_last
  );
endinterface

// File: rtl/vsq_quantizer.sv
// VSQ producer: buffers one vector, picks a power-of-two exponent from its max |x|,
// then streams rounded/saturated narrow elements. Optional feature: VSQ_SAT_COUNT_EN.
module vsq_quantizer #(
  parameter int VEC_LEN = 16,
  parameter int IN_W    = 24,
  parameter int Q_W     = 4,
  parameter int SF_W    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  vsq_quantizer_if.slave bus
`ifdef VSQ_SAT_COUNT_EN
  ,
  input  logic           sat_clr,
  output logic [15:0]    sat_cnt
`endif
);

  localparam int CNT_W = $clog2(VEC_LEN);
  localparam int S_W   = $clog2(IN_W);
  localparam int QMAX  = 2 ** (Q_W - 1) - 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
  localparam logic [IN_W-1:0]  QMAX_U   = IN_W'(QMAX);
  localparam logic [IN_W:0]    QMAX_R   = (IN_W + 1)'(QMAX);

  typedef enum logic [1:0] {COLLECT, SCALE, EMIT} state_t;

  state_t state, state_nxt;

  logic signed [IN_W-1:0] vec_p0 [VEC_LEN];
  logic [IN_W-1:0]        max_abs_p0;
  logic [CNT_W-1:0]       cnt;
  logic                   en_lat;
  logic [S_W-1:0]         sf_p1;

  logic in_ready, out_valid, out_last;
  logic accept, emit_hs;
  logic signed [IN_W-1:0] cur;
  logic [IN_W-1:0]        mag_in;
  logic [IN_W:0]          r_cur;
  logic signed [Q_W-1:0]  q_cur;

  // Magnitude as unsigned so the most negative input maps to 2^(IN_W-1).
  function automatic logic [IN_W-1:0] abs_val(input logic signed [IN_W-1:0] x);
    return x[IN_W-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  function automatic logic [S_W-1:0] calc_scale(input logic [IN_W-1:0] m);
    logic [S_W-1:0] s;
    s = S_W'(IN_W - 1);
    for (int i = IN_W - 1; i >= 0; i--)
      if ((m >> i) <= QMAX_U) s = S_W'(i);
    return s;
  endfunction

  function automatic logic [IN_W:0] round_mag(input logic [IN_W-1:0] mag,
                                              input logic [S_W-1:0]  s);
    logic [IN_W:0] sum;
    sum = {1'b0, mag};
    if (s != '0) sum = sum + ((IN_W + 1)'(1) << (s - 1'b1));
    return sum >> s;
  endfunction

  // Saturating to +QMAX before applying the sign keeps the code symmetric.
  function automatic logic signed [Q_W-1:0] sat_q(input logic neg, input logic [IN_W:0] r);
    logic signed [Q_W-1:0] m;
    m = (r > QMAX_R) ? Q_W'(QMAX) : $signed(r[Q_W-1:0]);
    return neg ? -m : m;
  endfunction

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (bus.in_valid && cnt == LAST_IDX) state_nxt = SCALE;
      end
      SCALE: state_nxt = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        out_last  = (cnt == LAST_IDX);
        if (bus.out_ready && cnt == LAST_IDX) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  assign accept  = bus.in_valid && in_ready;
  assign emit_hs = out_valid && bus.out_ready;
  assign mag_in  = abs_val(bus.in_data);

  // Stage p0: collect elements and track the running max magnitude.
  always_ff @(posedge clk) begin
    if (accept) vec_p0[cnt] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      max_abs_p0 <= '0;
      en_lat     <= 1'b0;
      sf_p1      <= '0;
    end else begin
      if (accept) begin
        cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        if (mag_in > max_abs_p0) max_abs_p0 <= mag_in;
        if (cnt == '0) en_lat <= bus.vsq_en;
      end
      // Stage p1: one-cycle exponent search over the finished vector.
      if (state == SCALE) sf_p1 <= en_lat ? calc_scale(max_abs_p0) : '0;
      if (emit_hs) begin
        if (cnt == LAST_IDX) begin
          cnt        <= '0;
          max_abs_p0 <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Stage p2: quantize the addressed element; stable while cnt and sf_p1 hold.
  assign cur   = vec_p0[cnt];
  assign r_cur = round_mag(abs_val(cur), sf_p1);
  assign q_cur = sat_q(cur[IN_W-1], r_cur);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_q     = out_valid ? q_cur : '0;
  assign bus.out_sf    = out_valid ? SF_W'(sf_p1) : '0;

`ifdef VSQ_SAT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          sat_cnt <= '0;
    else if (sat_clr)                                    sat_cnt <= '0;
    else if (emit_hs && r_cur > QMAX_R && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vsq_quantizer.sv
// Directed bench for vsq_quantizer with hand-computed quantized outputs.
module tb_vsq_quantizer;
  localparam int VEC_LEN = 16;
  localparam int IN_W    = 24;
  localparam int Q_W     = 4;
  localparam int SF_W    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vsq_quantizer_if #(.IN_W(IN_W), .Q_W(Q_W), .SF_W(SF_W)) bus ();

`ifdef VSQ_SAT_COUNT_EN
  logic        sat_clr = 1'b0;
  logic [15:0] sat_cnt;
`endif

  vsq_quantizer #(.VEC_LEN(VEC_LEN), .IN_W(IN_W), .Q_W(Q_W), .SF_W(SF_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
`ifdef VSQ_SAT_COUNT_EN
    ,
    .sat_clr(sat_clr),
    .sat_cnt(sat_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int vin  [VEC_LEN];
  int qexp [VEC_LEN];

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_vec();
    for (int i = 0; i < VEC_LEN; i++) begin
      vin[i]  = 0;
      qexp[i] = 0;
    end
  endtask

  // vsq_en is inverted after the first element: only the first one may count.
  task automatic send_vec(input logic en);
    for (int i = 0; i < VEC_LEN; i++) begin
      check("in_ready_collect", 32'(bus.in_ready), 1);
      bus.vsq_en   = (i == 0) ? en : ~en;
      bus.in_valid = 1'b1;
      bus.in_data  = IN_W'(vin[i]);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    check("out_valid_scale", 32'(bus.out_valid), 0);
    check("in_ready_scale", 32'(bus.in_ready), 0);
    step();
  endtask

  task automatic recv_vec(input int sf, input int n, input int stall_at);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = IN_W'(1000);
        repeat (5) begin
          step();
          check("stall_q", $signed(bus.out_q), qexp[i]);
          check("stall_sf", 32'(bus.out_sf), sf);
          check("stall_vld", 32'(bus.out_valid), 1);
          check("stall_last", 32'(bus.out_last), 0);
          check("stall_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
      end
      check("out_valid", 32'(bus.out_valid), 1);
      check("out_q", $signed(bus.out_q), qexp[i]);
      check("out_sf", 32'(bus.out_sf), sf);
      check("out_last", 32'(bus.out_last), (i == VEC_LEN - 1) ? 1 : 0);
      if (i < n - 1 || n == VEC_LEN) step();
    end
    if (n == VEC_LEN) begin
      check("done_out_valid", 32'(bus.out_valid), 0);
      check("done_in_ready", 32'(bus.in_ready), 1);
    end
  endtask

  initial begin
    bus.vsq_en    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_q", $signed(bus.out_q), 0);
    check("rst_out_sf", 32'(bus.out_sf), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
`ifdef VSQ_SAT_COUNT_EN
    check("rst_sat_cnt", 32'(sat_cnt), 0);
`endif
    rst_n = 1'b1;
    step();

    // All zeros
    clear_vec();
    send_vec(1'b1);
    recv_vec(0, VEC_LEN, -1);

    // 100 -> 6, -24 -> -2 at s=4
    clear_vec();
    vin[0] = 100; qexp[0] = 6;
    vin[1] = -24; qexp[1] = -2;
    send_vec(1'b1);
    recv_vec(4, VEC_LEN, -1);

    // 120 rounds to 8 and saturates to 7
    clear_vec();
    vin[0] = 120; qexp[0] = 7;
    send_vec(1'b1);
    recv_vec(4, VEC_LEN, -1);
`ifdef VSQ_SAT_COUNT_EN
    check("sat_cnt_1", 32'(sat_cnt), 1);
`endif
    send_vec(1'b1);
    recv_vec(4, VEC_LEN, -1);
`ifdef VSQ_SAT_COUNT_EN
    check("sat_cnt_2", 32'(sat_cnt), 2);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_cnt_clr", 32'(sat_cnt), 0);
`endif

    // Full-scale extremes: max |x| = 2^23 -> s=21
    clear_vec();
    vin[0] = -8388608; qexp[0] = -4;
    vin[1] = 8388607;  qexp[1] = 4;
    send_vec(1'b1);
    recv_vec(21, VEC_LEN, -1);

    // Scaling disabled: s=0, saturate 100 to 7
    clear_vec();
    vin[0] = 100; qexp[0] = 7;
    vin[1] = -3;  qexp[1] = -3;
    send_vec(1'b0);
    recv_vec(0, VEC_LEN, -1);

    // Backpressure on element 2 with in_valid driven during EMIT
    clear_vec();
    vin[0] = 100; qexp[0] = 6;
    vin[1] = -24; qexp[1] = -2;
    vin[2] = 50;  qexp[2] = 3;
    vin[3] = -40; qexp[3] = -3;
    send_vec(1'b1);
    recv_vec(4, VEC_LEN, 2);

    // Following vector must be clean after the ignored inputs
    clear_vec();
    vin[0] = 120; qexp[0] = 7;
    vin[5] = -9;  qexp[5] = -1;
    send_vec(1'b1);
    recv_vec(4, VEC_LEN, -1);

    // Async reset in the middle of EMIT
    clear_vec();
    vin[0] = 100; qexp[0] = 6;
    vin[1] = -24; qexp[1] = -2;
    send_vec(1'b1);
    recv_vec(4, 3, -1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_out_q", $signed(bus.out_q), 0);
    check("midrst_out_sf", 32'(bus.out_sf), 0);
    check("midrst_out_last", 32'(bus.out_last), 0);
    step();
    rst_n = 1'b1;
    step();
    check("postrst_in_ready", 32'(bus.in_ready), 1);
    check("postrst_out_valid", 32'(bus.out_valid), 0);

    clear_vec();
    vin[0] = 7; qexp[0] = 7;
    send_vec(1'b1);
    recv_vec(0, VEC_LEN, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vsq_quantizer.md
Name: vsq_quantizer

Overview:
- Producer side of the VSQ datapath. Collects a vector of wide signed values, derives one power-of-two scale exponent per vector from its max magnitude, then emits narrow signed quantized elements with that exponent.
- The emitted elements and exponents feed the per-vector scale inputs of the VSQ partial-sum path.
- Single vector buffer. Phases are collect, scale, emit.

Parameters:
- VEC_LEN, 16, elements per vector (power of two, ≥2)
- IN_W, 24, signed input element width
- Q_W, 4, signed quantized element width; QMAX = 2^(Q_W-1)-1 (7 by default)
- SF_W, 8, scale exponent output width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- vsq_en  in  1  per-vector scaling enable; sampled on the first accepted element of each vector
- in_valid  in  1  input element valid
- in_ready  out  1  block can accept an element
- in_data  in  IN_W  signed input element
- out_valid  out  1  quantized element valid
- out_ready  in  1  downstream accepts
- out_q  out  Q_W  signed quantized element
- out_sf  out  SF_W  scale exponent s for the current vector, zero-extended
- out_last  out  1  high on the final element of a vector

Behaviour:
- Reset (async assert, sync deassert) values:
  - in_ready=1; out_valid=0, out_q=0, out_sf=0, out_last=0
  - state=COLLECT; element count=0; max register=0; latched vsq_en=0
- FSM COLLECT:
  - in_ready=1.
  - On in_valid&in_ready: write in_data to buffer[cnt] and update max_abs = max(max_abs, |in_data|).
  - |x| is computed as IN_W-bit unsigned, so -2^(IN_W-1) gives 2^(IN_W-1) with no overflow.
  - Latch vsq_en when cnt==0.
  - When the accepted element has cnt==VEC_LEN-1: go to SCALE, cnt←0.
- FSM SCALE (exactly 1 cycle):
  - in_ready=0, out_valid=0.
  - If latched vsq_en: s = smallest value in 0..IN_W-1 with (max_abs >> s) ≤ QMAX.
  - Else: s=0.
  - Register s, then go to EMIT.
- FSM EMIT:
  - in_ready=0. out_valid=1. out_q is the quantized buffer[cnt], out_sf=s, out_last=(cnt==VEC_LEN-1).
  - On out_ready: cnt++.
  - On the handshake of the last element: go to COLLECT, clear max_abs and cnt, and drop out_valid the next cycle.
  - While out_valid=1 and out_ready=0, out_q/out_sf/out_last are held stable.
- Quantization:
  - mag = |x|.
  - If s>0: r = (mag + 2^(s-1)) >> s, i.e. round half away from zero. If s=0: r=mag.
  - Saturate r to QMAX, then apply the sign of x.
  - Result is always in [-QMAX, QMAX]; -QMAX-1 is never produced.
- Latency: the last input accept is at cycle T, SCALE is at T+1, the first out_valid is at T+2.
- Throughput: VEC_LEN+1+VEC_LEN cycles per vector with no backpressure.
- Boundaries:
  - in_valid while in_ready=0 is ignored, with no side effects.
  - A vsq_en change mid-vector has no effect until the next vector.
  - All-zero vector gives s=0 and all q=0.
  - Async reset mid-EMIT or mid-COLLECT discards the vector. Outputs go to reset values immediately.

Optional Feature:
- Macro VSQ_SAT_COUNT_EN.
- When defined:
  - Adds output sat_cnt [15:0] plus input sat_clr [0:0].
  - sat_cnt increments once per emitted element (on handshake) whose r before saturation exceeded QMAX.
  - sat_cnt sticks at 16'hFFFF.
  - sat_clr zeroes it synchronously, with priority over increment.
  - Reset value is 0.
- When undefined: the ports and counter are absent, and behaviour is otherwise identical.

Test Plan:
- 16 zeros, vsq_en=1 → out_sf=0, all out_q=0, out_last only on the 16th output, first out_valid 2 cycles after the last input.
- vsq_en=1, vector {100, -24, 0×14} → s=4; out_q 6, -2, then 0s; out_sf=4 on every element.
- vsq_en=1, vector {120, 0×15} → s=4, out_q=7 (saturated from 8), and with VSQ_SAT_COUNT_EN sat_cnt=1.
  - Repeat the vector → sat_cnt=2.
  - Pulse sat_clr → 0.
- vsq_en=1, vector {-8388608, 8388607, 0×14} → s=21; out_q -4, 4.
- vsq_en=0, vector {100, -3, 0×14} → s=0; out_q 7, -3.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles mid-EMIT → outputs stable, in_ready=0 throughout.
  - Drive in_valid during EMIT → ignored, the next vector is unaffected.
  - Assert rst_n=0 mid-EMIT → out_valid=0 immediately, in_ready=1 after release.
  - Next vector {7, 0×15} → s=0, q=7.
